// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C slave arbiter: rx bus field offsets, idle tx value, FSM encoding.
package i2c_arb_pkg;

  localparam int RX_W         = 21;
  localparam int RX_STOP      = 20;
  localparam int RX_ADDRESSED = 0;

  // SDA released, no ACK driven
  localparam logic [1:0] TX_IDLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLAIM     = 2'd1,
    OWNED     = 2'd2,
    UNCLAIMED = 2'd3
  } arb_state_e;

  // Saturating increment for a counter of up to 32 bits, truncated by the caller.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val == max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/i2c_arb_prio_enc.sv
// Lowest-index priority encoder over the slave ACK vector; also flags multiple requesters.
// Purely combinational.
module i2c_arb_prio_enc #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_SLAVES-1:0] req_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  any_o,
  output logic                  multi_o
);

  always_comb begin
    idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only when two or more were set
  assign multi_o = |(req_i & (req_i - NUM_SLAVES'(1)));

endmodule

// File: rtl/i2c_slave_arbiter.sv
// Selects which slave's {tx_content, ack} drives the shared i2c_frontend, locking ownership per packet
// at the address ACK slot; owner routed 2 clk after the address strobe; keeps packet/NACK/conflict stats.
module i2c_slave_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [20:0]             frontend_rx,
  output logic [1:0]              frontend_tx,
  input  logic [2*NUM_SLAVES-1:0] slave_tx,
  input  logic                    clear_stats,
  output logic [IDX_W-1:0]        owner,
  output logic                    owner_valid,
  output logic                    conflict,
  output logic [CNT_W-1:0]        pkt_count,
  output logic [CNT_W-1:0]        nack_count
);

  import i2c_arb_pkg::*;

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic             owner_vld_q;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] nack_cnt_q, nack_cnt_d;

  logic                  rx_stop, rx_addressed;
  logic [NUM_SLAVES-1:0] ack_vec;
  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_any, enc_multi;
  logic                  claim_hit, claim_miss;
  logic [1:0]            tx_sel;
  logic                  unused_rx;

  assign rx_stop      = frontend_rx[RX_STOP];
  assign rx_addressed = frontend_rx[RX_ADDRESSED];
  assign unused_rx    = ^frontend_rx[RX_STOP-1:RX_ADDRESSED+1];

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ack_vec[i] = slave_tx[2*i];
    end
  end

  i2c_arb_prio_enc #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_prio_enc (
    .req_i   (ack_vec),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  assign claim_hit  = (state_q == CLAIM) &&  enc_any;
  assign claim_miss = (state_q == CLAIM) && !enc_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_addressed) begin
            state_q <= CLAIM;
          end
        end
        CLAIM: begin
          if (enc_any) begin
            owner_q     <= enc_idx;
            owner_vld_q <= 1'b1;
            state_q     <= OWNED;
          end else begin
            state_q <= UNCLAIMED;
          end
        end
        OWNED, UNCLAIMED: begin
          // A repeated start shows up as pkt_addressed dropping; re-arbitrate from IDLE
          if (rx_stop || !rx_addressed) begin
            owner_vld_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tx_sel = TX_IDLE;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (owner_q == IDX_W'(i)) begin
        tx_sel = slave_tx[2*i +: 2];
      end
    end
  end

  assign frontend_tx = (state_q == OWNED) ? tx_sel : TX_IDLE;

  // clear_stats overrides any increment or conflict set landing in the same cycle
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    nack_cnt_d = nack_cnt_q;
    conflict_d = conflict_q;
    if (claim_hit) begin
      pkt_cnt_d  = CNT_W'(sat_inc(32'(pkt_cnt_q), 32'({CNT_W{1'b1}})));
      conflict_d = conflict_q | enc_multi;
    end
    if (claim_miss) begin
      nack_cnt_d = CNT_W'(sat_inc(32'(nack_cnt_q), 32'({CNT_W{1'b1}})));
    end
    if (clear_stats) begin
      pkt_cnt_d  = '0;
      nack_cnt_d = '0;
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      nack_cnt_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      nack_cnt_q <= nack_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign owner       = owner_q;
  assign owner_valid = owner_vld_q;
  assign conflict    = conflict_q;
  assign pkt_count   = pkt_cnt_q;
  assign nack_count  = nack_cnt_q;

endmodule

// File: tb/tb_i2c_slave_arbiter.sv
// Scoreboard bench for i2c_slave_arbiter; counters are built 4 bits wide so saturation is reachable.
module tb_i2c_slave_arbiter;
  import i2c_arb_pkg::*;

  localparam int NS = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [20:0]   frontend_rx = '0;
  logic [1:0]    frontend_tx;
  logic [2*NS-1:0] slave_tx = '0;
  logic          clear_stats = 1'b0;
  logic [IW-1:0] owner;
  logic          owner_valid;
  logic          conflict;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] nack_count;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] exp_pkt = '0;
  logic [CW-1:0] exp_nack = '0;
  logic          exp_conflict = 1'b0;
  logic [IW-1:0] exp_owner_q[$];

  i2c_slave_arbiter #(.NUM_SLAVES(NS), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frontend_rx (frontend_rx),
    .frontend_tx (frontend_tx),
    .slave_tx    (slave_tx),
    .clear_stats (clear_stats),
    .owner       (owner),
    .owner_valid (owner_valid),
    .conflict    (conflict),
    .pkt_count   (pkt_count),
    .nack_count  (nack_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase with the given slave tx pattern; compare the claim result.
  task automatic claim_pkt(input logic [2*NS-1:0] stx, input logic clr);
    logic          any;
    logic          multi;
    logic [IW-1:0] lowest;
    logic [IW-1:0] got_owner;
    int            nacks;
    logic          seen;
    any = 1'b0; multi = 1'b0; lowest = '0; nacks = 0;
    for (int i = 0; i < NS; i++) begin
      if (stx[2*i]) begin
        if (!any) lowest = IW'(i);
        nacks++;
        any = 1'b1;
      end
    end
    multi = (nacks >= 2);
    if (any) begin
      exp_owner_q.push_back(lowest);
      if (exp_pkt != 4'hF) exp_pkt = exp_pkt + 4'd1;
      if (multi) exp_conflict = 1'b1;
    end else begin
      if (exp_nack != 4'hF) exp_nack = exp_nack + 4'd1;
    end
    if (clr) begin
      exp_pkt = '0; exp_nack = '0; exp_conflict = 1'b0;
    end
    slave_tx = stx;
    frontend_rx[RX_ADDRESSED] = 1'b1;
    tick();
    checks++;
    if (frontend_tx !== TX_IDLE) begin
      errors++;
      $display("FAIL claim_tx: frontend_tx=%b expected %b", frontend_tx, TX_IDLE);
    end
    clear_stats = clr;
    tick();
    clear_stats = 1'b0;
    if (any) begin
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        if (owner_valid === 1'b1) seen = 1'b1;
        else tick();
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL owner_valid_timeout: owner_valid=%b expected 1", owner_valid);
        void'(exp_owner_q.pop_front());
      end else begin
        got_owner = exp_owner_q.pop_front();
        checks++;
        if (owner !== got_owner) begin
          errors++;
          $display("FAIL owner: got %0d expected %0d", owner, got_owner);
        end
      end
    end else begin
      checks++;
      if (owner_valid !== 1'b0) begin
        errors++;
        $display("FAIL unclaimed_valid: owner_valid=%b expected 0", owner_valid);
      end
    end
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL pkt_count: got %0d expected %0d", pkt_count, exp_pkt);
    end
    checks++;
    if (nack_count !== exp_nack) begin
      errors++;
      $display("FAIL nack_count: got %0d expected %0d", nack_count, exp_nack);
    end
    checks++;
    if (conflict !== exp_conflict) begin
      errors++;
      $display("FAIL conflict: got %b expected %b", conflict, exp_conflict);
    end
  endtask

  task automatic end_pkt();
    frontend_rx[RX_STOP] = 1'b1;
    frontend_rx[RX_ADDRESSED] = 1'b0;
    tick();
    frontend_rx[RX_STOP] = 1'b0;
    checks++;
    if (owner_valid !== 1'b0 || frontend_tx !== TX_IDLE) begin
      errors++;
      $display("FAIL stop_release: owner_valid=%b frontend_tx=%b expected 0/%b", owner_valid, frontend_tx, TX_IDLE);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (frontend_tx !== TX_IDLE) begin errors++; $display("FAIL reset_tx: got %b expected 10", frontend_tx); end
    checks++;
    if (owner !== '0 || owner_valid !== 1'b0) begin
      errors++; $display("FAIL reset_owner: owner=%0d valid=%b expected 0/0", owner, owner_valid);
    end
    checks++;
    if (conflict !== 1'b0 || pkt_count !== '0 || nack_count !== '0) begin
      errors++; $display("FAIL reset_stats: conflict=%b pkt=%0d nack=%0d expected 0/0/0", conflict, pkt_count, nack_count);
    end
  endtask

  task automatic test_single_claim();
    logic [1:0] v;
    claim_pkt(8'b00_01_00_00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      slave_tx[5:4] = v;
      slave_tx[7:6] = ~v;
      slave_tx[1:0] = v ^ 2'b01;
      #1;
      checks++;
      if (frontend_tx !== v) begin
        errors++; $display("FAIL single_track: frontend_tx=%b expected %b", frontend_tx, v);
      end
    end
    end_pkt();
    checks++;
    if (owner !== 2'd2) begin errors++; $display("FAIL owner_hold: owner=%0d expected 2", owner); end
  endtask

  task automatic test_conflict();
    logic [1:0] v;
    claim_pkt(8'b01_00_01_00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      slave_tx[7:6] = v;
      #1;
      checks++;
      if (frontend_tx !== 2'b01) begin
        errors++; $display("FAIL conflict_isolate: frontend_tx=%b expected 01", frontend_tx);
      end
    end
    end_pkt();
  endtask

  task automatic test_no_claim();
    claim_pkt(8'b10_10_10_10, 1'b0);
    checks++;
    if (dut.state_q !== UNCLAIMED) begin
      errors++; $display("FAIL noclaim_state: state=%0d expected %0d", dut.state_q, UNCLAIMED);
    end
    for (int i = 0; i < 3; i++) begin
      slave_tx = 8'($urandom_range(0, 255)) & 8'b10_10_10_10;
      tick();
      checks++;
      if (frontend_tx !== TX_IDLE) begin
        errors++; $display("FAIL noclaim_tx: frontend_tx=%b expected 10", frontend_tx);
      end
    end
    end_pkt();
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL noclaim_idle: state=%0d expected %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_repeated_start();
    claim_pkt(8'b00_00_00_01, 1'b0);
    frontend_rx[RX_ADDRESSED] = 1'b0;
    tick();
    checks++;
    if (owner_valid !== 1'b0) begin
      errors++; $display("FAIL rstart_gap: owner_valid=%b expected 0", owner_valid);
    end
    claim_pkt(8'b01_00_00_00, 1'b0);
    end_pkt();
  endtask

  task automatic test_saturation_clear();
    for (int n = 0; n < 20 && exp_pkt != 4'hF; n++) begin
      claim_pkt(8'b00_00_01_00, 1'b0);
      end_pkt();
    end
    claim_pkt(8'b00_01_00_00, 1'b0);
    checks++;
    if (pkt_count !== 4'hF) begin
      errors++; $display("FAIL saturate: pkt_count=%0d expected 15", pkt_count);
    end
    end_pkt();
    claim_pkt(8'b00_01_01_00, 1'b1);
    end_pkt();
  endtask

  task automatic test_async_reset();
    claim_pkt(8'b00_00_00_01, 1'b0);
    slave_tx[1:0] = 2'b00;
    #1;
    checks++;
    if (frontend_tx !== 2'b00) begin
      errors++; $display("FAIL pre_reset_ack: frontend_tx=%b expected 00", frontend_tx);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (frontend_tx !== TX_IDLE || owner_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: frontend_tx=%b owner_valid=%b expected 10/0", frontend_tx, owner_valid);
    end
    checks++;
    if (pkt_count !== '0 || owner !== '0) begin
      errors++; $display("FAIL async_reset_regs: pkt=%0d owner=%0d expected 0/0", pkt_count, owner);
    end
    frontend_rx = '0;
    exp_pkt = '0; exp_nack = '0; exp_conflict = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    #1;
    test_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_claim();
    test_conflict();
    test_no_claim();
    test_repeated_start();
    test_saturation_clear();
    test_async_reset();
    checks++;
    if (exp_owner_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_owner_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
